game_flow_ctrl: RTL and testbench
=================================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter TICK_PERIOD, default 1000: clk cycles per game tick, minimum 2.
REQ-002 Parameter COUNTDOWN_TICKS, default 3: ticks in the pre-run countdown, range 1..3.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 key_start  in  1  raw start key level, active-high.
REQ-006 key_pause  in  1  raw pause/resume key level, active-high.
REQ-007 key_restart  in  1  raw restart key level, active-high; the same physical key the game core uses for restart.
REQ-008 collision_detected  in  1  latched collision flag from the game core.
REQ-009 game_cleared  in  1  latched cleared flag from the game core.
REQ-010 run_game  out  1  enables the game core; high only in RUN.
REQ-011 game_state  out  3  state code: IDLE=0, COUNT=1, RUN=2, PAUSE=3, OVER=4, CLEAR=5.
REQ-012 countdown  out  2  remaining countdown ticks; 0 outside COUNT.
REQ-013 score  out  8  two packed BCD digits of ticks survived, tens digit in [7:4].
REQ-014 blink  out  1  toggles every tick in OVER or CLEAR; 0 otherwise.

Function
REQ-015 Each key input is sampled by a 2-flop synchroniser followed by a rising-edge detector, giving a 1-cycle pulse per press; holding a key produces no further pulses.
REQ-016 The tick counter runs 0..TICK_PERIOD-1 and issues a 1-cycle tick when it wraps; it is cleared on every state change and held at its current value in IDLE and PAUSE.
REQ-017 IDLE: a start pulse moves to COUNT, loads countdown=COUNTDOWN_TICKS, and clears score to 0x00.
REQ-018 COUNT: each tick decrements countdown; a tick while countdown==1 moves to RUN and sets countdown=0.
REQ-019 RUN: collision_detected=1 moves to OVER; otherwise game_cleared=1 moves to CLEAR; otherwise a pause pulse moves to PAUSE; otherwise a tick increments score in BCD (09->10, 99 saturates at 99).
REQ-020 PAUSE: a pause pulse moves back to RUN; score and the tick counter are frozen; collision/cleared inputs are ignored.
REQ-021 OVER, CLEAR: blink is cleared on entry and toggles on each tick; score is held.
REQ-022 A restart pulse in any state moves to IDLE, clears score, countdown and blink, and has priority over every other event in the same cycle.
REQ-023 Same-cycle priority order: restart > collision > cleared > pause > start > tick.
REQ-024 run_game, game_state, countdown, score and blink are registered outputs; run_game rises on the first clk edge after the RUN-entering tick and falls on the edge that leaves RUN.
REQ-025 Start pulses outside IDLE and pause pulses outside RUN/PAUSE are ignored.

Reset
REQ-026 On rst_n=0: state=IDLE, run_game=0, game_state=0, countdown=0, score=0x00, blink=0, and all synchroniser, edge-detector and tick registers are 0.
REQ-027 Reset asserted mid-game returns immediately to IDLE with no pulse generated on release, even if a key is held.

Structure
REQ-028 State codes and the BCD saturation value 0x99 live in the shared game package; both this block and the display logic import them.
REQ-029 A single sub-module, tick_gen (parameterised prescaler with enable and clear), provides the tick; edge detection is inline.

Verification (TICK_PERIOD=4, COUNTDOWN_TICKS=3)
REQ-030 Bench case, reset then start press: countdown reads 3,2,1 at 4-cycle spacing; run_game=1 and game_state=2 exactly 12 cycles after the start pulse.
REQ-031 Bench case, RUN for 40 ticks: score reads 0x40; forcing 99 ticks leaves score at 0x99.
REQ-032 Bench case, RUN then pause press, wait 20 cycles, pause press: run_game=0 during the gap, score unchanged, tick phase resumes where it stopped.
REQ-033 Bench case, collision_detected and game_cleared both high in RUN: next state is OVER (4), run_game=0, and blink toggles every 4 cycles.
REQ-034 Bench case, restart and collision in the same cycle during RUN: state is IDLE, score=0x00, run_game=0.
REQ-035 Bench case, key_start held high across a reset release: no transition out of IDLE until the key is released and pressed again.

Source files
------------

// File: rtl/game_flow_ctrl_pkg.sv
// rtl/game_flow_ctrl_pkg.sv - shared game state codes and BCD score helper
package game_flow_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_COUNT = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;
    localparam logic [2:0] ST_CLEAR = 3'd5;

    localparam logic [7:0] SCORE_MAX = 8'h99;

    // Two-digit BCD increment that sticks at SCORE_MAX.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = s[7:4];
        lo = s[3:0];
        if (s == SCORE_MAX) begin
            return s;
        end else if (lo == 4'd9) begin
            hi = hi + 4'd1;
            return {hi, 4'h0};
        end else begin
            lo = lo + 4'd1;
            return {hi, lo};
        end
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - game tick prescaler with enable and synchronous clear
module tick_gen #(
    parameter int PERIOD = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en & (cnt == LAST);

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game flow FSM: key conditioning, countdown, BCD score, blink
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int TICK_PERIOD     = 1000,
    parameter int COUNTDOWN_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       key_restart,
    input  logic       collision_detected,
    input  logic       game_cleared,
    output logic       run_game,
    output logic [2:0] game_state,
    output logic [1:0] countdown,
    output logic [7:0] score,
    output logic       blink
);

    localparam logic [1:0] CD_INIT = 2'(COUNTDOWN_TICKS);

    // Bit order: {restart, pause, start}.
    logic [2:0] key_s1, key_s2, key_prev, key_armed, key_pulse;
    logic [1:0] sync_fill;

    // A key only arms once it has been seen released after reset, so a key held
    // through reset release cannot fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1    <= '0;
            key_s2    <= '0;
            key_prev  <= '0;
            key_armed <= '0;
            sync_fill <= '0;
        end else begin
            key_s1    <= {key_restart, key_pause, key_start};
            key_s2    <= key_s1;
            key_prev  <= key_s2;
            key_armed <= key_armed | ({3{sync_fill == 2'd2}} & ~key_s2);
            if (sync_fill != 2'd2) begin
                sync_fill <= sync_fill + 2'd1;
            end
        end
    end

    assign key_pulse = key_armed & key_s2 & ~key_prev;

    logic       start_p, pause_p, restart_p;
    logic       tick, tick_en, tick_clr;
    logic [2:0] state, state_n;
    logic [1:0] cd_n;
    logic [7:0] score_n;
    logic       blink_n;

    assign start_p   = key_pulse[0];
    assign pause_p   = key_pulse[1];
    assign restart_p = key_pulse[2];

    assign tick_en = (state != ST_IDLE) && (state != ST_PAUSE);
    // RUN<->PAUSE keeps the tick phase so a pause freezes rather than resets it.
    assign tick_clr = (state_n != state) &&
                      !((state == ST_RUN && state_n == ST_PAUSE) ||
                        (state == ST_PAUSE && state_n == ST_RUN));

    tick_gen #(
        .PERIOD (TICK_PERIOD)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_n = state;
        cd_n    = countdown;
        score_n = score;
        blink_n = blink;
        if (restart_p) begin
            state_n = ST_IDLE;
            cd_n    = 2'd0;
            score_n = 8'h00;
            blink_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_p) begin
                        state_n = ST_COUNT;
                        cd_n    = CD_INIT;
                        score_n = 8'h00;
                    end
                end
                ST_COUNT: begin
                    if (tick) begin
                        if (countdown == 2'd1) begin
                            state_n = ST_RUN;
                            cd_n    = 2'd0;
                        end else begin
                            cd_n = countdown - 2'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (collision_detected) begin
                        state_n = ST_OVER;
                        blink_n = 1'b0;
                    end else if (game_cleared) begin
                        state_n = ST_CLEAR;
                        blink_n = 1'b0;
                    end else if (pause_p) begin
                        state_n = ST_PAUSE;
                    end else if (tick) begin
                        score_n = bcd_inc(score);
                    end
                end
                ST_PAUSE: begin
                    if (pause_p) begin
                        state_n = ST_RUN;
                    end
                end
                ST_OVER, ST_CLEAR: begin
                    if (tick) begin
                        blink_n = ~blink;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            run_game  <= 1'b0;
            countdown <= 2'd0;
            score     <= 8'h00;
            blink     <= 1'b0;
        end else begin
            state     <= state_n;
            run_game  <= (state_n == ST_RUN);
            countdown <= cd_n;
            score     <= score_n;
            blink     <= blink_n;
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed self-checking bench for game_flow_ctrl
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_start = 1'b0;
    logic       key_pause = 1'b0;
    logic       key_restart = 1'b0;
    logic       collision_detected = 1'b0;
    logic       game_cleared = 1'b0;
    logic       run_game;
    logic [2:0] game_state;
    logic [1:0] countdown;
    logic [7:0] score;
    logic       blink;

    int n_cmp = 0;
    int n_bad = 0;

    game_flow_ctrl #(
        .TICK_PERIOD     (4),
        .COUNTDOWN_TICKS (3)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .key_start          (key_start),
        .key_pause          (key_pause),
        .key_restart        (key_restart),
        .collision_detected (collision_detected),
        .game_cleared       (game_cleared),
        .run_game           (run_game),
        .game_state         (game_state),
        .countdown          (countdown),
        .score              (score),
        .blink              (blink)
    );

    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Key goes high 1ns after an edge; its pulse acts on the third edge.
    task automatic press(input int which);
        if (which == 0) key_start = 1'b1;
        if (which == 1) key_pause = 1'b1;
        if (which == 2) key_restart = 1'b1;
        edges(3);
        key_start = 1'b0;
        key_pause = 1'b0;
        key_restart = 1'b0;
    endtask

    task automatic start_to_run();
        press(0);
        edges(12);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        edges(2);
        n_cmp++; if (run_game !== 1'b0) begin n_bad++; $display("FAIL reset_run_game got %0b want 0", run_game); end
        n_cmp++; if (game_state !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", game_state); end
        n_cmp++; if (countdown !== 2'd0) begin n_bad++; $display("FAIL reset_countdown got %0d want 0", countdown); end
        n_cmp++; if (score !== 8'h00) begin n_bad++; $display("FAIL reset_score got %h want 00", score); end
        n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL reset_blink got %0b want 0", blink); end
        rst_n = 1'b1;
        edges(5);
    endtask

    task automatic test_countdown();
        press(0);
        n_cmp++; if (game_state !== 3'd1) begin n_bad++; $display("FAIL cd_state got %0d want 1", game_state); end
        n_cmp++; if (countdown !== 2'd3) begin n_bad++; $display("FAIL cd_3 got %0d want 3", countdown); end
        edges(4);
        n_cmp++; if (countdown !== 2'd2) begin n_bad++; $display("FAIL cd_2 got %0d want 2", countdown); end
        edges(4);
        n_cmp++; if (countdown !== 2'd1) begin n_bad++; $display("FAIL cd_1 got %0d want 1", countdown); end
        edges(3);
        n_cmp++; if (run_game !== 1'b0) begin n_bad++; $display("FAIL cd_run_early got %0b want 0", run_game); end
        edges(1);
        n_cmp++; if (run_game !== 1'b1) begin n_bad++; $display("FAIL cd_run_at12 got %0b want 1", run_game); end
        n_cmp++; if (game_state !== 3'd2) begin n_bad++; $display("FAIL cd_state_run got %0d want 2", game_state); end
        n_cmp++; if (countdown !== 2'd0) begin n_bad++; $display("FAIL cd_0 got %0d want 0", countdown); end
    endtask

    task automatic test_score();
        edges(40);
        n_cmp++; if (score !== 8'h10) begin n_bad++; $display("FAIL score_10 got %h want 10", score); end
        edges(120);
        n_cmp++; if (score !== 8'h40) begin n_bad++; $display("FAIL score_40 got %h want 40", score); end
        edges(396);
        n_cmp++; if (score !== 8'h99) begin n_bad++; $display("FAIL score_sat got %h want 99", score); end
        edges(8);
        n_cmp++; if (score !== 8'h99) begin n_bad++; $display("FAIL score_sat_hold got %h want 99", score); end
    endtask

    task automatic test_pause();
        press(2);
        n_cmp++; if (game_state !== 3'd0) begin n_bad++; $display("FAIL restart_state got %0d want 0", game_state); end
        n_cmp++; if (score !== 8'h00) begin n_bad++; $display("FAIL restart_score got %h want 00", score); end
        start_to_run();
        n_cmp++; if (game_state !== 3'd2) begin n_bad++; $display("FAIL pause_prerun got %0d want 2", game_state); end
        edges(2);
        press(1);
        n_cmp++; if (game_state !== 3'd3) begin n_bad++; $display("FAIL pause_state got %0d want 3", game_state); end
        n_cmp++; if (run_game !== 1'b0) begin n_bad++; $display("FAIL pause_run got %0b want 0", run_game); end
        n_cmp++; if (score !== 8'h01) begin n_bad++; $display("FAIL pause_score got %h want 01", score); end
        edges(10);
        n_cmp++; if (run_game !== 1'b0) begin n_bad++; $display("FAIL pause_gap_run got %0b want 0", run_game); end
        n_cmp++; if (score !== 8'h01) begin n_bad++; $display("FAIL pause_gap_score got %h want 01", score); end
        edges(10);
        press(1);
        n_cmp++; if (game_state !== 3'd2) begin n_bad++; $display("FAIL resume_state got %0d want 2", game_state); end
        n_cmp++; if (run_game !== 1'b1) begin n_bad++; $display("FAIL resume_run got %0b want 1", run_game); end
        edges(2);
        n_cmp++; if (score !== 8'h01) begin n_bad++; $display("FAIL resume_phase_early got %h want 01", score); end
        edges(1);
        n_cmp++; if (score !== 8'h02) begin n_bad++; $display("FAIL resume_phase got %h want 02", score); end
    endtask

    task automatic test_over();
        collision_detected = 1'b1;
        game_cleared = 1'b1;
        edges(1);
        collision_detected = 1'b0;
        game_cleared = 1'b0;
        n_cmp++; if (game_state !== 3'd4) begin n_bad++; $display("FAIL over_state got %0d want 4", game_state); end
        n_cmp++; if (run_game !== 1'b0) begin n_bad++; $display("FAIL over_run got %0b want 0", run_game); end
        n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL over_blink0 got %0b want 0", blink); end
        edges(3);
        n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL over_blink3 got %0b want 0", blink); end
        edges(1);
        n_cmp++; if (blink !== 1'b1) begin n_bad++; $display("FAIL over_blink4 got %0b want 1", blink); end
        edges(4);
        n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL over_blink8 got %0b want 0", blink); end
        n_cmp++; if (score !== 8'h02) begin n_bad++; $display("FAIL over_score got %h want 02", score); end
    endtask

    task automatic test_clear();
        press(2);
        n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL clr_restart_blink got %0b want 0", blink); end
        start_to_run();
        game_cleared = 1'b1;
        edges(1);
        game_cleared = 1'b0;
        n_cmp++; if (game_state !== 3'd5) begin n_bad++; $display("FAIL clear_state got %0d want 5", game_state); end
        n_cmp++; if (run_game !== 1'b0) begin n_bad++; $display("FAIL clear_run got %0b want 0", run_game); end
    endtask

    task automatic test_restart_collision();
        press(2);
        start_to_run();
        edges(8);
        n_cmp++; if (score !== 8'h02) begin n_bad++; $display("FAIL rc_pre_score got %h want 02", score); end
        key_restart = 1'b1;
        edges(2);
        collision_detected = 1'b1;
        edges(1);
        key_restart = 1'b0;
        n_cmp++; if (game_state !== 3'd0) begin n_bad++; $display("FAIL rc_state got %0d want 0", game_state); end
        n_cmp++; if (score !== 8'h00) begin n_bad++; $display("FAIL rc_score got %h want 00", score); end
        n_cmp++; if (run_game !== 1'b0) begin n_bad++; $display("FAIL rc_run got %0b want 0", run_game); end
        collision_detected = 1'b0;
        edges(2);
        n_cmp++; if (game_state !== 3'd0) begin n_bad++; $display("FAIL rc_stay got %0d want 0", game_state); end
    endtask

    task automatic test_held_start_reset();
        key_start = 1'b1;
        edges(3);
        n_cmp++; if (game_state !== 3'd1) begin n_bad++; $display("FAIL hs_count got %0d want 1", game_state); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (game_state !== 3'd0) begin n_bad++; $display("FAIL hs_async got %0d want 0", game_state); end
        n_cmp++; if (countdown !== 2'd0) begin n_bad++; $display("FAIL hs_async_cd got %0d want 0", countdown); end
        edges(2);
        rst_n = 1'b1;
        edges(10);
        n_cmp++; if (game_state !== 3'd0) begin n_bad++; $display("FAIL hs_held got %0d want 0", game_state); end
        key_start = 1'b0;
        edges(5);
        n_cmp++; if (game_state !== 3'd0) begin n_bad++; $display("FAIL hs_release got %0d want 0", game_state); end
        press(0);
        n_cmp++; if (game_state !== 3'd1) begin n_bad++; $display("FAIL hs_repress got %0d want 1", game_state); end
        n_cmp++; if (countdown !== 2'd3) begin n_bad++; $display("FAIL hs_repress_cd got %0d want 3", countdown); end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_score();
        test_pause();
        test_over();
        test_clear();
        test_restart_collision();
        test_held_start_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
